// File: rtl/i2c_master_ctrl.sv
// Command-driven I2C master: one single-byte register write or read per command.
// Define I2C_MASTER_CLK_STRETCH_EN to let a slave stretch the SCL-high quarters.
module i2c_master_ctrl #(
  parameter int unsigned CLK_DIV = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmdValid,
  output logic       cmdReady,
  input  logic       cmdRead,
  input  logic [6:0] devAddr,
  input  logic [7:0] regAddr,
  input  logic [7:0] wrData,
  output logic       rspValid,
  output logic [7:0] rdData,
  output logic       ackErr,
  output logic       busy,
  output logic       sclOut,
  input  logic       sclIn,
  output logic       sdaOut,
  input  logic       sdaIn
);
  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    Idle, Start, SendByte, GetAck, Restart, RecvByte, SendNack, Stop, Done
  } state_e;

  state_e          state;
  logic [CntW-1:0] cnt;
  logic [1:0]      qtr;
  logic [1:0]      byteIdx;
  logic [2:0]      bitIdx;
  logic            isRead;
  logic            err;
  logic [6:0]      devAddrQ;
  logic [7:0]      regAddrQ;
  logic [7:0]      wrDataQ;
  logic [7:0]      txShift;
  logic [7:0]      rxShift;
  logic            accept;
  logic            isBit;
  logic            sclHighPh;
  logic            hold;
  logic            lastCyc;

  assign accept    = cmdValid && cmdReady;
  assign isBit     = state inside {SendByte, GetAck, RecvByte, SendNack};
  assign sclHighPh = (isBit && qtr == 2'd2) ||
                     ((state inside {Restart, Stop}) && (qtr == 2'd1 || qtr == 2'd2));

`ifdef I2C_MASTER_CLK_STRETCH_EN
  assign hold = sclHighPh && !sclIn;
`else
  logic unusedScl;
  assign unusedScl = sclIn ^ sclHighPh;
  assign hold      = 1'b0;
`endif

  assign lastCyc = (cnt == CntW'(CLK_DIV - 1)) && !hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= Idle;
      cnt      <= '0;
      qtr      <= '0;
      bitIdx   <= '0;
      byteIdx  <= '0;
      isRead   <= 1'b0;
      err      <= 1'b0;
      devAddrQ <= '0;
      regAddrQ <= '0;
      wrDataQ  <= '0;
      txShift  <= '0;
      rxShift  <= '0;
      cmdReady <= 1'b1;
      busy     <= 1'b0;
      rspValid <= 1'b0;
      rdData   <= '0;
      ackErr   <= 1'b0;
      sclOut   <= 1'b1;
      sdaOut   <= 1'b1;
    end else begin
      rspValid <= 1'b0;
      if (state != Idle && state != Done) begin
        cnt <= (hold || lastCyc) ? '0 : cnt + 1'b1;
        if (lastCyc) qtr <= qtr + 2'd1;
      end
      // Every bit cell: SCL low for Q0/Q1, high for Q2/Q3.
      if (isBit && lastCyc) begin
        if (qtr == 2'd1) sclOut <= 1'b1;
        if (qtr == 2'd3) sclOut <= 1'b0;
      end
      unique case (state)
        Idle, Done: begin
          state <= Idle;
          if (accept) begin
            // Bus already sits at START Q0 levels, so the accept cycle counts as its first cycle.
            state    <= Start;
            cnt      <= CntW'(1);
            qtr      <= '0;
            bitIdx   <= '0;
            byteIdx  <= '0;
            isRead   <= cmdRead;
            err      <= 1'b0;
            devAddrQ <= devAddr;
            regAddrQ <= regAddr;
            wrDataQ  <= wrData;
            txShift  <= {devAddr, 1'b0};
            rxShift  <= '0;
            cmdReady <= 1'b0;
            busy     <= 1'b1;
          end
        end
        Start: if (lastCyc) begin
          if (qtr == 2'd0) begin
            sdaOut <= 1'b0;
          end else begin
            state  <= SendByte;
            qtr    <= '0;
            sclOut <= 1'b0;
            sdaOut <= txShift[7];
          end
        end
        SendByte: if (lastCyc && qtr == 2'd3) begin
          if (bitIdx == 3'd7) begin
            state  <= GetAck;
            bitIdx <= '0;
            sdaOut <= 1'b1;
          end else begin
            bitIdx  <= bitIdx + 3'd1;
            txShift <= {txShift[6:0], 1'b0};
            sdaOut  <= txShift[6];
          end
        end
        GetAck: if (lastCyc) begin
          if (qtr == 2'd2) err <= sdaIn;
          if (qtr == 2'd3) begin
            if (err) begin
              state  <= Stop;
              sdaOut <= 1'b0;
            end else if (byteIdx == 2'd0) begin
              state   <= SendByte;
              byteIdx <= 2'd1;
              txShift <= regAddrQ;
              sdaOut  <= regAddrQ[7];
            end else if (byteIdx == 2'd1 && isRead) begin
              state  <= Restart;
              sdaOut <= 1'b1;
            end else if (byteIdx == 2'd1) begin
              state   <= SendByte;
              byteIdx <= 2'd2;
              txShift <= wrDataQ;
              sdaOut  <= wrDataQ[7];
            end else if (isRead) begin
              state  <= RecvByte;
              sdaOut <= 1'b1;
            end else begin
              state  <= Stop;
              sdaOut <= 1'b0;
            end
          end
        end
        Restart: if (lastCyc) begin
          if (qtr == 2'd0)      sclOut <= 1'b1;
          else if (qtr == 2'd1) sdaOut <= 1'b0;
          else if (qtr == 2'd2) sclOut <= 1'b0;
          else begin
            state   <= SendByte;
            byteIdx <= 2'd2;
            txShift <= {devAddrQ, 1'b1};
            sdaOut  <= devAddrQ[6];
          end
        end
        RecvByte: if (lastCyc) begin
          if (qtr == 2'd2) rxShift <= {rxShift[6:0], sdaIn};
          if (qtr == 2'd3) begin
            if (bitIdx == 3'd7) begin
              state  <= SendNack;
              bitIdx <= '0;
            end else begin
              bitIdx <= bitIdx + 3'd1;
            end
          end
        end
        SendNack: if (lastCyc && qtr == 2'd3) begin
          state  <= Stop;
          sdaOut <= 1'b0;
        end
        Stop: if (lastCyc) begin
          if (qtr == 2'd0)      sclOut <= 1'b1;
          else if (qtr == 2'd1) sdaOut <= 1'b1;
          else if (qtr == 2'd3) begin
            state    <= Done;
            rspValid <= 1'b1;
            cmdReady <= 1'b1;
            busy     <= 1'b0;
            rdData   <= err ? 8'h00 : rxShift;
            ackErr   <= err;
          end
        end
        default: state <= Idle;
      endcase
    end
  end

endmodule

// File: doc/i2c_master_ctrl.md
# i2c_master_ctrl

Command-driven I2C master that generates SCL/SDA to perform single-byte register writes and reads against the `i2cSlave` register file. It sits directly upstream of the slave on the open-drain bus: the bench or host logic issues one command, and the block runs the full bus transaction. It returns read data and ACK status with a one-cycle response pulse.

## Interface
- `CLK_DIV`, 64: clk cycles per SCL quarter-period (SCL period = 4·CLK_DIV); legal minimum 8.
- `clk` in 1: sole clock.
- `rst` in 1: reset, synchronous, active-high.
- `cmdValid` in 1: command request.
- `cmdReady` out 1: block idle, command accepted when `cmdValid && cmdReady`.
- `cmdRead` in 1: 1 = register read, 0 = register write.
- `devAddr` in 7: slave device address.
- `regAddr` in 8: register address.
- `wrData` in 8: write data (ignored on read).
- `rspValid` out 1: one-cycle pulse, transaction finished.
- `rdData` out 8: read byte, valid with `rspValid`.
- `ackErr` out 1: a NACK was received, valid with `rspValid`.
- `busy` out 1: transaction in progress.
- `sclOut` out 1: 0 drives SCL low, 1 releases it.
- `sclIn` in 1: resolved SCL line level.
- `sdaOut` out 1: 0 drives SDA low, 1 releases it.
- `sdaIn` in 1: resolved SDA line level.

## Operation
- Reset values: `cmdReady`=1, `busy`=0, `rspValid`=0, `rdData`=0, `ackErr`=0, `sclOut`=1, `sdaOut`=1; state IDLE.
- On accept, latch all command fields. Next cycle: `cmdReady`=0, `busy`=1.
- States: IDLE → START → SEND_BYTE → GET_ACK → (SEND_BYTE | RESTART | RECV_BYTE | STOP) … → SEND_NACK → STOP → DONE → IDLE.
- Write sequence: START, {devAddr,0}, ACK, regAddr, ACK, wrData, ACK, STOP.
- Read sequence: START, {devAddr,0}, ACK, regAddr, ACK, RESTART, {devAddr,1}, ACK, 8 data bits, master NACK (SDA released), STOP.
- Bytes are sent MSB first.
- If any GET_ACK samples `sdaIn`=1: set the error flag, skip the remaining bytes, go to STOP. Result is `ackErr`=1, `rdData`=0.
- DONE lasts one cycle. It asserts `rspValid`=1 and `cmdReady`=1, and drops `busy`. `rdData`/`ackErr` hold until the next `rspValid`.
- `cmdValid` while `cmdReady`=0 is ignored; nothing is queued.
- `rst` mid-transaction: next cycle, IDLE with all reset values. No `rspValid` is produced, and the bus is released.

## Timing
- Quarter counter counts 0..CLK_DIV-1. Each phase below is one quarter.
- START: Q0 SCL=1 SDA=1; Q1 SCL=1 SDA=0.
- Bit (data, ACK, NACK): Q0 SCL=0, SDA updated on its first cycle; Q1 SCL=0; Q2 SCL=1; Q3 SCL=1.
- `sdaIn` is sampled on the last cycle of Q2.
- RESTART: Q0 SCL=0 SDA=1; Q1 SCL=1 SDA=1; Q2 SCL=1 SDA=0; Q3 SCL=0 SDA=0.
- STOP: Q0 SCL=0 SDA=0; Q1 SCL=1 SDA=0; Q2 SCL=1 SDA=1; Q3 idle.
- SDA never changes while SCL=1, except in START, RESTART and STOP.
- Write duration: 2 + 27·4 + 4 = 114 quarters.
- Read duration: 2 + 18·4 + 4 + 18·4 + 4 = 154 quarters.
- NACK abort: STOP immediately follows the failing ACK bit.
- `rspValid` is asserted on the cycle after the final STOP quarter.

## Configuration
- Macro: `I2C_MASTER_CLK_STRETCH_EN`.
- Defined: in bit Q2 and in RESTART/STOP SCL-high quarters, the quarter counter holds at 0 while `sclIn`=0 (slave stretching). It resumes counting when `sclIn`=1.
- Undefined: `sclIn` is ignored; timing is fixed exactly as in Timing.

## Test plan
- Write path: CLK_DIV=16, write devAddr 0x3C, regAddr 0x02, wrData 0xA5, to the slave at 0x3C. Required: slave myReg2 = 0xA5; `rspValid` 1824 cycles after the accept cycle; `ackErr`=0.
- Read path: slave myReg5 = 0x5A; read devAddr 0x3C, regAddr 0x05. Required: `rdData`=0x5A, `ackErr`=0, 2464 cycles.
- Wrong address: write to devAddr 0x11. Required: NACK on the first ACK bit, STOP follows, `ackErr`=1, `rdData`=0, `rspValid` after 2+9·4+4 = 42 quarters.
- Reset mid-transaction: assert `rst` during regAddr bit 3. Required: next cycle `sclOut`=`sdaOut`=1, `cmdReady`=1, no `rspValid`. A following write completes normally.
- Back-to-back: hold `cmdValid` with two writes (0x11 to reg 0, then 0x22 to reg 1). Required: second accept on the `rspValid` cycle; slave myReg0 = 0x11, myReg1 = 0x22. `cmdValid` pulsed while busy is ignored.
- Clock stretching: hold `sclIn`=0 for 100 cycles during a data-bit Q2. With the macro defined, the transaction lengthens by 100 cycles. Without it, the length is unchanged.
